// File: rtl/udp_pkt_recv.sv
// UDP receive path: GMII byte stream in, filtered UDP payload out with
// header metadata, IP checksum / FCS verification and a per-packet status pulse.
module udp_pkt_recv #(
  parameter bit          ACCEPT_BCAST = 1'b1,
  parameter int unsigned MAX_PREAMBLE = 7
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  i_rx_data,
  input  logic        i_rx_dv,
  input  logic        i_rx_er,
  input  logic [47:0] i_local_mac,
  input  logic [31:0] i_local_ip,
  input  logic [15:0] i_local_port,
  output logic [7:0]  o_data,
  output logic        o_data_vl,
  output logic        o_sop,
  output logic        o_eop,
  output logic [47:0] o_src_mac,
  output logic [31:0] o_src_ip,
  output logic [15:0] o_src_port,
  output logic [15:0] o_data_len,
  output logic        o_pkt_done,
  output logic        o_pkt_ok,
  output logic [15:0] o_drop_cnt
);

  typedef enum logic [2:0] {
    S_IDLE, S_PREAMBLE, S_HEADER, S_PAYLOAD, S_TAIL, S_DONE, S_DROP
  } state_t;

  localparam logic [7:0]  PRE_MAX = 8'(MAX_PREAMBLE);
  localparam logic [31:0] RESIDUE = 32'hDEBB20E3;

  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'h0, d};
    for (int unsigned i = 0; i < 8; i++)
      r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  state_t      state;
  logic [7:0]  pre_cnt;
  logic [5:0]  hdr_cnt;
  logic [7:0]  prev;
  logic        loc, bc, err, full, csum_ok, eop_q;
  logic [15:0] csum, ip_len, udp_len, pay_cnt;
  logic [31:0] crc;
  logic [47:0] src_mac_sh;
  logic [31:0] src_ip_sh;
  logic [15:0] src_port_sh;

  logic [31:0] crc_next;
  logic [16:0] csum_s17;
  logic [15:0] csum_next, udp_w;
  logic [7:0]  mac_byte, ip_byte, port_byte;
  logic        loc_n, bc_n, hdr_fail, drop_now;

  always_comb begin
    crc_next  = crc_byte(crc, i_rx_data);
    csum_s17  = {1'b0, csum} + {1'b0, prev, i_rx_data};
    csum_next = csum_s17[15:0] + {15'b0, csum_s17[16]};
    udp_w     = {prev, i_rx_data};
    mac_byte  = 8'(i_local_mac >> {3'(6'd5 - hdr_cnt), 3'b000});
    ip_byte   = 8'(i_local_ip >> {2'(6'd33 - hdr_cnt), 3'b000});
    port_byte = 8'(i_local_port >> {1'(6'd37 - hdr_cnt), 3'b000});
    loc_n     = loc & (i_rx_data == mac_byte);
    bc_n      = bc & (i_rx_data == 8'hFF);
    hdr_fail  = 1'b0;
    case (hdr_cnt) inside
      [6'd0:6'd5]:   hdr_fail = !(loc_n | bc_n);
      6'd12:         hdr_fail = (i_rx_data != 8'h08);
      6'd13:         hdr_fail = (i_rx_data != 8'h00);
      6'd14:         hdr_fail = (i_rx_data != 8'h45);
      6'd23:         hdr_fail = (i_rx_data != 8'h11);
      [6'd30:6'd33]: hdr_fail = (i_rx_data != ip_byte);
      6'd36, 6'd37:  hdr_fail = (i_rx_data != port_byte);
      6'd39:         hdr_fail = (udp_w < 16'd8) || ((17'(udp_w) + 17'd20) > 17'(ip_len));
      default:       hdr_fail = 1'b0;
    endcase
    drop_now = 1'b0;
    case (state)
      S_IDLE:     drop_now = i_rx_dv && (i_rx_data != 8'h55);
      S_PREAMBLE: drop_now = !i_rx_dv
                             || ((i_rx_data == 8'h55) && (pre_cnt == PRE_MAX))
                             || ((i_rx_data != 8'h55) && (i_rx_data != 8'hD5));
      S_HEADER:   drop_now = !i_rx_dv || hdr_fail;
      default:    drop_now = 1'b0;
    endcase
  end

  // A payload byte is only known to be the last one when dv falls in the
  // cycle it sits on o_data, so the truncation case is folded in here.
  assign o_eop = eop_q | (o_data_vl & (state == S_PAYLOAD) & ~i_rx_dv);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;  pre_cnt <= '0;  hdr_cnt <= '0;  prev <= '0;
      loc <= 1'b0;  bc <= 1'b0;  err <= 1'b0;  full <= 1'b0;  csum_ok <= 1'b0;
      eop_q <= 1'b0;  csum <= '0;  ip_len <= '0;  udp_len <= '0;  pay_cnt <= '0;
      crc <= '1;  src_mac_sh <= '0;  src_ip_sh <= '0;  src_port_sh <= '0;
      o_data <= '0;  o_data_vl <= 1'b0;  o_sop <= 1'b0;
      o_src_mac <= '0;  o_src_ip <= '0;  o_src_port <= '0;  o_data_len <= '0;
      o_pkt_done <= 1'b0;  o_pkt_ok <= 1'b0;  o_drop_cnt <= '0;
    end else begin
      o_data_vl  <= 1'b0;
      o_sop      <= 1'b0;
      eop_q      <= 1'b0;
      o_pkt_done <= 1'b0;
      o_pkt_ok   <= 1'b0;
      if (i_rx_dv && i_rx_er) err <= 1'b1;
      if (i_rx_dv && (state inside {S_HEADER, S_PAYLOAD, S_TAIL})) crc <= crc_next;
      if (drop_now) begin
        state      <= S_DROP;
        o_drop_cnt <= o_drop_cnt + 16'd1;
      end else begin
        case (state)
          S_IDLE: if (i_rx_dv) begin
            state   <= S_PREAMBLE;
            pre_cnt <= 8'd1;
            err     <= i_rx_er;
          end
          S_PREAMBLE: if (i_rx_data == 8'h55) begin
            pre_cnt <= pre_cnt + 8'd1;
          end else begin
            state   <= S_HEADER;
            hdr_cnt <= '0;
            crc     <= '1;
            loc     <= 1'b1;
            bc      <= ACCEPT_BCAST;
            csum    <= '0;
            csum_ok <= 1'b0;
            full    <= 1'b0;
          end
          S_HEADER: begin
            hdr_cnt <= hdr_cnt + 6'd1;
            loc     <= loc_n;
            bc      <= bc_n;
            prev    <= i_rx_data;
            if (hdr_cnt[0] && hdr_cnt >= 6'd15 && hdr_cnt <= 6'd33) csum <= csum_next;
            if (hdr_cnt == 6'd33) csum_ok <= (csum_next == 16'hFFFF);
            case (hdr_cnt) inside
              [6'd6:6'd11]:  src_mac_sh  <= {src_mac_sh[39:0], i_rx_data};
              6'd17:         ip_len      <= udp_w;
              [6'd26:6'd29]: src_ip_sh   <= {src_ip_sh[23:0], i_rx_data};
              6'd34, 6'd35:  src_port_sh <= {src_port_sh[7:0], i_rx_data};
              6'd39:         udp_len     <= udp_w;
              6'd41: begin
                o_src_mac  <= src_mac_sh;
                o_src_ip   <= src_ip_sh;
                o_src_port <= src_port_sh;
                o_data_len <= udp_len - 16'd8;
                pay_cnt    <= '0;
                full       <= (udp_len == 16'd8);
                state      <= (udp_len == 16'd8) ? S_TAIL : S_PAYLOAD;
              end
              default: ;
            endcase
          end
          S_PAYLOAD: if (!i_rx_dv) begin
            state      <= S_DONE;
            o_pkt_done <= 1'b1;
          end else begin
            o_data    <= i_rx_data;
            o_data_vl <= 1'b1;
            o_sop     <= (pay_cnt == 16'd0);
            pay_cnt   <= pay_cnt + 16'd1;
            if (pay_cnt + 16'd1 == o_data_len) begin
              eop_q <= 1'b1;
              full  <= 1'b1;
              state <= S_TAIL;
            end
          end
          S_TAIL: if (!i_rx_dv) begin
            state      <= S_DONE;
            o_pkt_done <= 1'b1;
            o_pkt_ok   <= (crc == RESIDUE) && csum_ok && !err && full;
          end
          S_DONE:  state <= S_IDLE;
          S_DROP:  if (!i_rx_dv) state <= S_IDLE;
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_udp_pkt_recv.sv
// Bench for udp_pkt_recv: directed scenarios plus randomized frames checked
// against a field-level model of which frames are accepted and what they yield.
module tb_udp_pkt_recv;

  localparam logic [47:0] LMAC  = 48'h02_11_22_33_44_55;
  localparam logic [31:0] LIP   = 32'hC0A8_0102;
  localparam logic [15:0] LPORT = 16'd1234;
  localparam bit          BCAST = 1'b1;
  localparam int          MAXP  = 7;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  rx_data;
  logic        rx_dv, rx_er;
  logic [7:0]  o_data;
  logic        o_data_vl, o_sop, o_eop, o_pkt_done, o_pkt_ok;
  logic [47:0] o_src_mac;
  logic [31:0] o_src_ip;
  logic [15:0] o_src_port, o_data_len, o_drop_cnt;

  always #5 clk = ~clk;

  udp_pkt_recv #(.ACCEPT_BCAST(BCAST), .MAX_PREAMBLE(MAXP)) dut (
    .clk(clk), .rst_n(rst_n), .i_rx_data(rx_data), .i_rx_dv(rx_dv), .i_rx_er(rx_er),
    .i_local_mac(LMAC), .i_local_ip(LIP), .i_local_port(LPORT),
    .o_data(o_data), .o_data_vl(o_data_vl), .o_sop(o_sop), .o_eop(o_eop),
    .o_src_mac(o_src_mac), .o_src_ip(o_src_ip), .o_src_port(o_src_port),
    .o_data_len(o_data_len), .o_pkt_done(o_pkt_done), .o_pkt_ok(o_pkt_ok),
    .o_drop_cnt(o_drop_cnt)
  );

  typedef struct {
    logic [47:0] dst_mac, src_mac;
    logic [31:0] src_ip, dst_ip;
    logic [15:0] etype, ip_len, udp_len, src_port, dst_port;
    logic [7:0]  verihl, proto, pseed, pstep;
    int          pre_n, npad, cut, er_at, gap;
    bit          bad_csum, bad_fcs, rst_mid;
  } frm_t;

  typedef struct packed { logic [7:0] d; logic s; logic e; } pb_t;
  typedef struct packed { logic ok; logic [31:0] cyc; } dn_t;

  int          n_tests = 0, n_fail = 0, cyc = 0;
  logic [7:0]  tx_q[$];
  pb_t         got_q[$];
  dn_t         done_q[$];
  int          fall_q[$];
  logic [47:0] ex_mac = '0;
  logic [31:0] ex_ip = '0;
  logic [15:0] ex_port = '0, ex_len = '0, ex_drop = '0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) if (rst_n) begin
    if (o_data_vl) got_q.push_back('{d: o_data, s: o_sop, e: o_eop});
    if (o_pkt_done) done_q.push_back('{ok: o_pkt_ok, cyc: 32'(cyc)});
  end

  function automatic logic [7:0] pay_byte(input frm_t f, input int i);
    return 8'(int'(f.pseed) + int'(f.pstep) * i);
  endfunction

  function automatic frm_t mk(input int udp_len);
    frm_t f;
    f.dst_mac = LMAC;  f.src_mac = 48'({$urandom, $urandom});
    f.src_ip = $urandom;  f.dst_ip = LIP;
    f.src_port = 16'($urandom);  f.dst_port = LPORT;
    f.etype = 16'h0800;  f.verihl = 8'h45;  f.proto = 8'h11;
    f.udp_len = 16'(udp_len);  f.ip_len = 16'(udp_len + 20);
    f.pseed = 8'($urandom);  f.pstep = 8'($urandom) | 8'h01;
    f.pre_n = 7;  f.npad = $urandom_range(0, 6);  f.cut = -1;  f.er_at = -1;  f.gap = 3;
    f.bad_csum = 1'b0;  f.bad_fcs = 1'b0;  f.rst_mid = 1'b0;
    return f;
  endfunction

  task automatic build(input frm_t f);
    logic [7:0]  h[0:41];
    logic [7:0]  body[$];
    logic [31:0] crc, fcs;
    logic [15:0] cs;
    int s, npay;
    tx_q.delete();
    repeat (f.pre_n) tx_q.push_back(8'h55);
    tx_q.push_back(8'hD5);
    for (int i = 0; i < 42; i++) h[i] = 8'h00;
    for (int i = 0; i < 6; i++) begin
      h[i]     = f.dst_mac[47 - 8*i -: 8];
      h[6 + i] = f.src_mac[47 - 8*i -: 8];
    end
    {h[12], h[13]} = f.etype;  h[14] = f.verihl;  {h[16], h[17]} = f.ip_len;
    {h[18], h[19]} = 16'($urandom);  h[22] = 8'd64;  h[23] = f.proto;
    {h[26], h[27], h[28], h[29]} = f.src_ip;  {h[30], h[31], h[32], h[33]} = f.dst_ip;
    {h[34], h[35]} = f.src_port;  {h[36], h[37]} = f.dst_port;  {h[38], h[39]} = f.udp_len;
    s = 0;
    for (int i = 14; i < 34; i += 2) s += int'({h[i], h[i+1]});
    while (s > 32'hFFFF) s = (s & 32'hFFFF) + (s >> 16);
    cs = ~16'(s);
    h[24] = cs[15:8];  h[25] = cs[7:0] ^ {7'b0, f.bad_csum};
    for (int i = 0; i < 42; i++) body.push_back(h[i]);
    npay = (f.udp_len >= 16'd8) ? int'(f.udp_len) - 8 : 0;
    for (int i = 0; i < npay; i++) body.push_back(pay_byte(f, i));
    for (int i = 0; i < f.npad; i++) body.push_back(8'($urandom));
    crc = 32'hFFFF_FFFF;
    foreach (body[j]) for (int k = 0; k < 8; k++) begin
      logic fb;
      fb  = crc[0] ^ body[j][k];
      crc = crc >> 1;
      if (fb) crc = crc ^ 32'hEDB88320;
    end
    fcs = ~crc;
    fcs[31:24] = fcs[31:24] ^ {7'b0, f.bad_fcs};
    for (int k = 0; k < 4; k++) body.push_back(fcs[8*k +: 8]);
    foreach (body[j]) tx_q.push_back(body[j]);
  endtask

  task automatic send(input frm_t f);
    int n, base;
    build(f);
    base = f.pre_n + 1;
    n = (f.cut < 0) ? tx_q.size() : base + f.cut;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      rx_data = tx_q[i];  rx_dv = 1'b1;
      rx_er = (f.er_at >= 0) && (i == base + f.er_at);
    end
    if (f.rst_mid) begin
      #3;
      chk("pre_rst_vl", o_data_vl, 1'b1);
      rst_n = 1'b0;
      #1;
      chk("rst_out", {o_data, o_data_vl, o_sop, o_eop, o_pkt_done, o_pkt_ok, o_drop_cnt, o_data_len}, '0);
      chk("rst_meta", {o_src_mac, o_src_ip, o_src_port}, '0);
      rx_dv = 1'b0;  rx_er = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      got_q.delete();  done_q.delete();  fall_q.delete();
      ex_mac = '0;  ex_ip = '0;  ex_port = '0;  ex_len = '0;  ex_drop = '0;
      return;
    end
    @(posedge clk); #1;
    rx_dv = 1'b0;  rx_er = 1'b0;
    fall_q.push_back(cyc);
    repeat (f.gap - 1) @(posedge clk);
  endtask

  function automatic bit accepted(input frm_t f);
    bit mac_ok;
    mac_ok = (f.dst_mac == LMAC) || (BCAST && f.dst_mac == 48'hFFFF_FFFF_FFFF);
    return f.pre_n >= 1 && f.pre_n <= MAXP && (f.cut < 0 || f.cut >= 42) && mac_ok
        && f.etype == 16'h0800 && f.verihl == 8'h45 && f.proto == 8'h11
        && f.dst_ip == LIP && f.dst_port == LPORT && f.udp_len >= 16'd8
        && int'(f.udp_len) <= int'(f.ip_len) - 20;
  endfunction

  task automatic expect_frm(input frm_t f, input bit meta);
    int  npay, recv, fall;
    bit  ok;
    dn_t d;
    pb_t g;
    repeat (4) @(posedge clk);
    #1;
    fall = (fall_q.size() != 0) ? fall_q.pop_front() : -1;
    if (accepted(f)) begin
      npay = int'(f.udp_len) - 8;
      recv = (f.cut < 0 || f.cut - 42 >= npay) ? npay : f.cut - 42;
      ok   = (f.cut < 0) && !f.bad_csum && !f.bad_fcs && (f.er_at < 0);
      chk("done_seen", done_q.size() != 0, 1'b1);
      if (done_q.size() != 0) begin
        d = done_q.pop_front();
        chk("pkt_ok", d.ok, ok);
        chk("done_lat", d.cyc, 32'(fall + 1));
      end
      for (int i = 0; i < recv; i++) begin
        if (got_q.size() == 0) begin
          chk("pay_cnt", i, recv);
          break;
        end
        g = got_q.pop_front();
        chk("pay_byte", g.d, pay_byte(f, i));
        chk("sop", g.s, i == 0);
        chk("eop", g.e, i == recv - 1);
      end
      ex_mac = f.src_mac;  ex_ip = f.src_ip;  ex_port = f.src_port;
      ex_len = f.udp_len - 16'd8;
    end else begin
      ex_drop = ex_drop + 16'd1;
    end
    if (meta) begin
      chk("src_mac", o_src_mac, ex_mac);
      chk("src_ip", o_src_ip, ex_ip);
      chk("src_port", o_src_port, ex_port);
      chk("data_len", o_data_len, ex_len);
      chk("drop_cnt", o_drop_cnt, ex_drop);
      chk("stray_pay", got_q.size(), 0);
      chk("stray_done", done_q.size(), 0);
      got_q.delete();
      done_q.delete();
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    frm_t f, f2;
    int m;
    rst_n = 1'b0;  rx_data = '0;  rx_dv = 1'b0;  rx_er = 1'b0;
    #22;
    chk("reset_out", {o_data, o_data_vl, o_sop, o_eop, o_pkt_done, o_pkt_ok, o_drop_cnt, o_data_len}, '0);
    chk("reset_meta", {o_src_mac, o_src_ip, o_src_port}, '0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // 1/2: reference frame, then FCS corrupted
    f = mk(18);  f.pseed = 8'h00;  f.pstep = 8'h01;  f.npad = 6;
    send(f);  expect_frm(f, 1'b1);
    f.bad_fcs = 1'b1;
    send(f);  expect_frm(f, 1'b1);
    // 3: port mismatch, then ARP ethertype
    f = mk(18);  f.dst_port = 16'd1235;
    send(f);  expect_frm(f, 1'b1);
    f = mk(18);  f.etype = 16'h0806;
    send(f);  expect_frm(f, 1'b1);
    // 4: broadcast accepted; bad IP checksum
    f = mk(20);  f.dst_mac = '1;
    send(f);  expect_frm(f, 1'b1);
    f = mk(20);  f.bad_csum = 1'b1;
    send(f);  expect_frm(f, 1'b1);
    // 5: truncated payload followed back-to-back by a good frame
    f = mk(18);  f.pseed = 8'h00;  f.pstep = 8'h01;  f.cut = 42 + 4;  f.gap = 1;
    f2 = mk(18);
    send(f);  send(f2);
    expect_frm(f, 1'b0);  expect_frm(f2, 1'b1);
    // preamble boundaries
    f = mk(12);  f.pre_n = 1;      send(f);  expect_frm(f, 1'b1);
    f = mk(12);  f.pre_n = MAXP+1; send(f);  expect_frm(f, 1'b1);
    f = mk(12);  f.pre_n = 0;      send(f);  expect_frm(f, 1'b1);

    for (int k = 0; k < 60; k++) begin
      f = mk($urandom_range(8, 48));
      f.pre_n = $urandom_range(1, MAXP);
      m = $urandom_range(0, 19);
      case (m)
        0:  f.dst_mac = LMAC ^ (48'h1 << $urandom_range(0, 47));
        1:  f.dst_mac = '1;
        2:  f.etype = 16'h0806;
        3:  f.verihl = 8'h46;
        4:  f.proto = 8'h06;
        5:  f.dst_ip = LIP ^ (32'h1 << $urandom_range(0, 31));
        6:  f.dst_port = LPORT ^ (16'h1 << $urandom_range(0, 15));
        7:  begin f.udp_len = 16'($urandom_range(0, 7)); f.ip_len = f.udp_len + 16'd20; end
        8:  f.ip_len = f.udp_len + 16'd19;
        9:  f.pre_n = ($urandom_range(0, 1) != 0) ? 0 : MAXP + 1;
        10: f.cut = $urandom_range(0, 41);
        11: if (f.udp_len > 16'd8) f.cut = 42 + $urandom_range(0, int'(f.udp_len) - 9);
        12: f.bad_csum = 1'b1;
        13: f.bad_fcs = 1'b1;
        14: f.er_at = $urandom_range(0, 41 + int'(f.udp_len) - 8);
        default: ;
      endcase
      send(f);
      expect_frm(f, 1'b1);
    end

    // 6: async reset mid-payload, then a zero-length payload frame
    f = mk(18);  f.cut = 42 + 5;  f.rst_mid = 1'b1;
    send(f);
    f = mk(8);
    send(f);  expect_frm(f, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
